// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seg7 display constants and marquee state type
package seg7_pkg;

   localparam logic [7:0]  SEG_BLANK     = 8'hFF;
   localparam logic [63:0] SEG_BLANK_WIN = {8{SEG_BLANK}};
   localparam logic        DISP_HEX      = 1'b0;
   localparam logic        DISP_RAW      = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_marquee_if.sv
// rtl/seg7_marquee_if.sv - control/data bundle between marquee host and seg7_marquee
interface seg7_marquee_if #(
   parameter int AW     = 5,
   parameter int STEP_W = 26
);
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [7:0]        wr_data;
   logic [AW:0]       msg_len;
   logic [STEP_W-1:0] step_cycles;
   logic              loop_en;
   logic              start;
   logic              stop;
   logic [31:0]       idle_value;
   logic [63:0]       o_data;
   logic              o_disp_mode;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data, msg_len, step_cycles, loop_en,
             start, stop, idle_value,
      input  o_data, o_disp_mode, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, msg_len, step_cycles, loop_en,
             start, stop, idle_value,
      output o_data, o_disp_mode, busy, done
   );
endinterface

// File: rtl/seg7_tick_gen.sv
// rtl/seg7_tick_gen.sv - step-period counter, one-cycle tick on terminal count
module seg7_tick_gen #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic [W-1:0] period,
   output logic         tick
);
   logic [W-1:0] cnt;

   // period is guaranteed >= 1 by the caller, so period-1 never wraps
   assign tick = en && (cnt == period - W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/seg7_marquee.sv
// rtl/seg7_marquee.sv - hex idle display / right-to-left scrolling segment marquee
module seg7_marquee
   import seg7_pkg::*;
#(
   parameter int MSG_DEPTH = 32,
   parameter int AW        = 5,
   parameter int STEP_W    = 26
) (
   input logic           clk,
   input logic           rstn,
   seg7_marquee_if.slave bus
);
   localparam int          IW      = AW + 2;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(MSG_DEPTH);

   state_t            state_q, state_d;
   logic [63:0]       data_q, data_d;
   logic              mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [AW:0]       len_q, len_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              loop_q, loop_d;
   logic [7:0]        msg_buf [MSG_DEPTH];
   logic [AW:0]       eff_len;
   logic [7:0]        next_char;
   logic              tick;

   assign eff_len   = (bus.msg_len > DEPTH_L) ? DEPTH_L : bus.msg_len;
   // past the message tail, blanks push the text off the left edge
   assign next_char = (idx_q < IW'(len_q)) ? msg_buf[idx_q[AW-1:0]] : SEG_BLANK;

   always_ff @(posedge clk) begin
      if (bus.wr_en && state_q == IDLE)
         msg_buf[bus.wr_addr] <= bus.wr_data;
   end

   seg7_tick_gen #(.W(STEP_W)) u_tick (
      .clk    (clk),
      .rstn   (rstn),
      .en     (state_q == RUN),
      .period (step_q),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         data_q  <= '0;
         mode_q  <= DISP_HEX;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         len_q   <= '0;
         step_q  <= '0;
         loop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         step_q  <= step_d;
         loop_q  <= loop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = {32'h0, bus.idle_value};
      mode_d  = DISP_HEX;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = idx_q;
      len_d   = len_q;
      step_d  = step_q;
      loop_d  = loop_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               if (eff_len != '0) begin
                  state_d = RUN;
                  data_d  = SEG_BLANK_WIN;
                  mode_d  = DISP_RAW;
                  busy_d  = 1'b1;
                  idx_d   = '0;
                  len_d   = eff_len;
                  step_d  = (bus.step_cycles == '0) ? STEP_W'(1) : bus.step_cycles;
                  loop_d  = bus.loop_en;
               end else begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               data_d = data_q;
               mode_d = DISP_RAW;
               busy_d = 1'b1;
               if (tick) begin
                  data_d = {data_q[55:0], next_char};
                  if (idx_q == IW'(len_q) + IW'(7)) begin
                     if (loop_q) begin
                        idx_d = '0;
                     end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        data_d  = {32'h0, bus.idle_value};
                        mode_d  = DISP_HEX;
                     end
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_data      = data_q;
   assign bus.o_disp_mode = mode_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_seg7_marquee.sv
// tb/tb_seg7_marquee.sv - scoreboard bench for seg7_marquee scrolling and idle display
module tb_seg7_marquee;
   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   seg7_marquee_if #(.AW(5), .STEP_W(26)) bus ();

   seg7_marquee #(.MSG_DEPTH(32), .AW(5), .STEP_W(26)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      string       tag;
      logic [66:0] v;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  mem [32];
   logic [31:0] idle;

   // window after t ticks of one pass: byte j holds char t-1-j, blank outside the message
   function automatic logic [63:0] win(int t, int len);
      logic [63:0] w;
      int k;
      for (int j = 0; j < 8; j++) begin
         k = t - 1 - j;
         w[j*8 +: 8] = (k >= 0 && k < len) ? mem[k] : 8'hFF;
      end
      return w;
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string tag, input logic [63:0] d, input logic m,
                       input logic b, input logic dn);
      exp_t e;
      e.tag = tag;
      e.v   = {d, m, b, dn};
      sb.push_back(e);
   endtask

   task automatic push_hex(input string tag, input logic dn);
      push(tag, {32'h0, idle}, 1'b0, 1'b0, dn);
   endtask

   task automatic plan_scroll(input string tag, input int len, input int ticks);
      push({tag, " entry"}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      for (int t = 1; t <= ticks; t++)
         push($sformatf("%s tick%0d", tag, t), win(t, len), 1'b1, 1'b1, 1'b0);
   endtask

   task automatic pop_check();
      exp_t e;
      logic [66:0] obs;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
         return;
      end
      e   = sb.pop_front();
      obs = {bus.o_data, bus.o_disp_mode, bus.busy, bus.done};
      assert (obs === e.v) else begin
         n_err++;
         $error("FAIL %s: observed data=%h mode=%b busy=%b done=%b expected data=%h mode=%b busy=%b done=%b",
                e.tag, obs[66:3], obs[2], obs[1], obs[0], e.v[66:3], e.v[2], e.v[1], e.v[0]);
      end
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(a);
      bus.wr_data = d;
      mem[a]      = d;
      step(1);
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      rstn            = 1'b0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.msg_len     = '0;
      bus.step_cycles = '0;
      bus.loop_en     = 1'b0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      idle            = 32'h1234_ABCD;
      bus.idle_value  = idle;

      // reset values, then hex idle display
      push("reset", 64'h0, 1'b0, 1'b0, 1'b0);
      step(1);
      pop_check();
      rstn = 1'b1;
      push_hex("t1 idle", 1'b0);
      step(2);
      pop_check();

      // "HI", step 4, single pass
      wr(0, 8'h89);
      wr(1, 8'hF9);
      bus.msg_len     = 6'd2;
      bus.step_cycles = 26'd4;
      bus.loop_en     = 1'b0;
      bus.start       = 1'b1;
      plan_scroll("t2", 2, 9);
      push_hex("t2 finish", 1'b1);
      push_hex("t2 idle", 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      for (int t = 1; t <= 9; t++) begin
         step(4);
         pop_check();
      end
      step(4);
      pop_check();
      step(1);
      pop_check();

      // oversized length clamps to depth, zero step behaves as one
      for (int i = 0; i < 32; i++)
         wr(i, 8'(8'h40 + i));
      bus.msg_len     = 6'd40;
      bus.step_cycles = 26'd0;
      bus.start       = 1'b1;
      plan_scroll("t3", 32, 39);
      push_hex("t3 finish", 1'b1);
      push_hex("t3 idle", 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      for (int t = 1; t <= 39; t++) begin
         step(1);
         pop_check();
      end
      step(1);
      pop_check();
      step(1);
      pop_check();

      // looping wraps seamlessly, stop aborts without done
      bus.msg_len     = 6'd3;
      bus.step_cycles = 26'd2;
      bus.loop_en     = 1'b1;
      bus.start       = 1'b1;
      plan_scroll("t4", 3, 11);
      push("t4 tick12", win(1, 3), 1'b1, 1'b1, 1'b0);
      push("t4 tick13", win(2, 3), 1'b1, 1'b1, 1'b0);
      push_hex("t4 stopped", 1'b0);
      push_hex("t4 stopped+1", 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      for (int t = 1; t <= 13; t++) begin
         step(2);
         pop_check();
      end
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      pop_check();
      step(1);
      pop_check();

      // start+stop together, then zero-length start
      bus.loop_en = 1'b0;
      bus.start   = 1'b1;
      bus.stop    = 1'b1;
      push_hex("t5 start_stop", 1'b0);
      push_hex("t5 start_stop+1", 1'b0);
      step(1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      pop_check();
      step(1);
      pop_check();
      bus.msg_len = 6'd0;
      bus.start   = 1'b1;
      push_hex("t5 len0 done", 1'b1);
      push_hex("t5 len0 after", 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      step(1);
      pop_check();
      idle           = 32'hDEAD_BEEF;
      bus.idle_value = idle;
      push_hex("t5 new idle", 1'b0);
      step(1);
      pop_check();

      // write during RUN is ignored
      bus.msg_len     = 6'd2;
      bus.step_cycles = 26'd1;
      bus.start       = 1'b1;
      plan_scroll("t6", 2, 9);
      push_hex("t6 finish", 1'b1);
      push_hex("t6 idle", 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd0;
      bus.wr_data = 8'h00;
      step(1);
      bus.wr_en = 1'b0;
      pop_check();
      for (int t = 2; t <= 9; t++) begin
         step(1);
         pop_check();
      end
      step(1);
      pop_check();
      step(1);
      pop_check();

      // rerun shows original char, then async reset mid-scroll
      bus.start = 1'b1;
      plan_scroll("t6 rerun", 2, 3);
      push("t6 async_reset", 64'h0, 1'b0, 1'b0, 1'b0);
      step(1);
      bus.start = 1'b0;
      pop_check();
      for (int t = 1; t <= 3; t++) begin
         step(1);
         pop_check();
      end
      #2 rstn = 1'b0;
      #1 pop_check();
      step(1);
      rstn = 1'b1;
      push_hex("t6 post_reset idle", 1'b0);
      step(2);
      pop_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
